// File: rtl/branch_target_unit_pkg.sv
// Shared definitions for the branch target unit: output-slot state encoding
// and the default address-arithmetic constants.
package branch_target_unit_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   localparam int SHIFT_DEF    = 2;
   localparam int PC_OFS_DEF   = 8;
   localparam int LINK_OFS_DEF = 4;

endpackage

// File: rtl/branch_target_unit_sign_ext.sv
// Sign-extends a raw offset field to the output width, then shifts it left
// to turn a word offset into a byte offset.
module sign_ext #(
   parameter int IN_W  = 24,
   parameter int OUT_W = 32,
   parameter int SH    = 2
) (
   input  logic [IN_W-1:0]  val_i,
   output logic [OUT_W-1:0] val_o
);

   logic [OUT_W-1:0] extended;

   assign extended = OUT_W'($signed(val_i));
   assign val_o    = extended << SH;

endmodule

// File: rtl/branch_target_unit.sv
// Branch target / return address calculator with a single registered output
// slot, valid/ready handshake, flush, and a count of taken branches delivered.
module branch_target_unit
   import branch_target_unit_pkg::*;
#(
   parameter int OFS_W    = 24,
   parameter int ADDR_W   = 32,
   parameter int SHIFT    = SHIFT_DEF,
   parameter int PC_OFS   = PC_OFS_DEF,
   parameter int LINK_OFS = LINK_OFS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] pc,
   input  logic [OFS_W-1:0]  ofst,
   input  logic              link,
   input  logic              cond_pass,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] link_addr,
   output logic              taken,
   output logic              link_we,
   output logic [15:0]       taken_cnt
);

   state_e            state_q;
   logic [ADDR_W-1:0] target_q, target_d;
   logic [ADDR_W-1:0] link_addr_q, link_addr_d;
   logic              taken_q, link_we_q;
   logic [15:0]       taken_cnt_q;
   logic [ADDR_W-1:0] ofs_shifted;
   logic              accept, deliver;

   sign_ext #(
      .IN_W  (OFS_W),
      .OUT_W (ADDR_W),
      .SH    (SHIFT)
   ) u_sign_ext (
      .val_i (ofst),
      .val_o (ofs_shifted)
   );

   assign target_d    = pc + ADDR_W'(PC_OFS) + ofs_shifted;
   assign link_addr_d = pc + ADDR_W'(LINK_OFS);

   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready && !flush;
   assign deliver   = out_valid && out_ready && taken_q && !flush;

   // taken/link_we are cleared whenever the slot empties so they read 0 while idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         target_q    <= '0;
         link_addr_q <= '0;
         taken_q     <= 1'b0;
         link_we_q   <= 1'b0;
         taken_cnt_q <= '0;
      end else begin
         if (deliver) begin
            taken_cnt_q <= taken_cnt_q + 16'd1;
         end
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q     <= FULL;
                  target_q    <= target_d;
                  link_addr_q <= link_addr_d;
                  taken_q     <= cond_pass;
                  link_we_q   <= link && cond_pass;
               end
            end
            FULL: begin
               if (flush) begin
                  state_q   <= EMPTY;
                  taken_q   <= 1'b0;
                  link_we_q <= 1'b0;
               end else if (accept) begin
                  target_q    <= target_d;
                  link_addr_q <= link_addr_d;
                  taken_q     <= cond_pass;
                  link_we_q   <= link && cond_pass;
               end else if (out_ready) begin
                  state_q   <= EMPTY;
                  taken_q   <= 1'b0;
                  link_we_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign target    = target_q;
   assign link_addr = link_addr_q;
   assign taken     = taken_q;
   assign link_we   = link_we_q;
   assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_target_unit.sv
// Self-checking bench for branch_target_unit: table-driven vectors, a
// behavioural scoreboard model, and hand-written handshake corner cases.
module tb_branch_target_unit;

   typedef struct {
      logic [31:0] pc;
      logic [23:0] ofst;
      logic        link;
      logic        cond;
      logic [31:0] expTarget;
      logic [31:0] expLink;
      logic        expTaken;
      logic        expLinkWe;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] pc;
   logic [23:0] ofst;
   logic        link, cond_pass, flush;
   logic        out_valid, out_ready;
   logic [31:0] target, link_addr;
   logic        taken, link_we;
   logic [15:0] taken_cnt;

   int compared   = 0;
   int mismatched = 0;
   logic checkEn  = 1'b0;

   vec_t        stimVec;
   vec_t        scoreQ[$];
   vec_t        tbl[6];
   logic        expFull;
   logic [15:0] expCnt;
   logic        modelReady, modelAcc;

   branch_target_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pc        (pc),
      .ofst      (ofst),
      .link      (link),
      .cond_pass (cond_pass),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .target    (target),
      .link_addr (link_addr),
      .taken     (taken),
      .link_we   (link_we),
      .taken_cnt (taken_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t refVec(input logic [31:0] p, input logic [23:0] o,
                                   input logic l, input logic c);
      vec_t v;
      logic [31:0] sx;
      sx          = {{8{o[23]}}, o};
      v.pc        = p;
      v.ofst      = o;
      v.link      = l;
      v.cond      = c;
      v.expTarget = p + 32'd8 + (sx << 2);
      v.expLink   = p + 32'd4;
      v.expTaken  = c;
      v.expLinkWe = l & c;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input logic valid, input logic rdy, input logic fl);
      @(posedge clk);
      #1;
      stimVec   = v;
      pc        = v.pc;
      ofst      = v.ofst;
      link      = v.link;
      cond_pass = v.cond;
      in_valid  = valid;
      out_ready = rdy;
      flush     = fl;
   endtask

   // Scoreboard model: results are queued on acceptance and retired on delivery or flush
   assign modelReady = !expFull || out_ready;
   assign modelAcc   = in_valid && modelReady && !flush;

   always @(posedge clk) begin
      if (!rst_n) begin
         scoreQ.delete();
         expFull <= 1'b0;
         expCnt  <= 16'd0;
      end else begin
         if (expFull && out_ready && !flush && scoreQ.size() > 0 && scoreQ[0].expTaken)
            expCnt <= expCnt + 16'd1;
         if (expFull && (flush || out_ready) && scoreQ.size() > 0)
            void'(scoreQ.pop_front());
         if (modelAcc)
            scoreQ.push_back(stimVec);
         expFull <= modelAcc || (expFull && !(flush || out_ready));
      end
   end

   always @(negedge clk) begin
      if (checkEn && rst_n) begin
         checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expFull});
         checkOutput("in_ready", {31'd0, in_ready}, {31'd0, modelReady});
         checkOutput("taken_cnt", {16'd0, taken_cnt}, {16'd0, expCnt});
         if (expFull) begin
            if (scoreQ.size() == 0) begin
               checkOutput("scoreboard_empty", 32'd0, 32'd1);
            end else begin
               checkOutput("target", target, scoreQ[0].expTarget);
               checkOutput("link_addr", link_addr, scoreQ[0].expLink);
               checkOutput("taken", {31'd0, taken}, {31'd0, scoreQ[0].expTaken});
               checkOutput("link_we", {31'd0, link_we}, {31'd0, scoreQ[0].expLinkWe});
            end
         end else begin
            checkOutput("idle_taken", {31'd0, taken}, 32'd0);
            checkOutput("idle_link_we", {31'd0, link_we}, 32'd0);
         end
      end
   end

   initial begin
      vec_t idle;
      vec_t pre;
      int   guard;

      tbl[0] = '{32'h00001000, 24'hD55555, 1'b0, 1'b1, 32'hFF55655C, 32'h00001004, 1'b1, 1'b0};
      tbl[1] = '{32'hFFFFFFF8, 24'h000001, 1'b1, 1'b1, 32'h00000004, 32'hFFFFFFFC, 1'b1, 1'b1};
      tbl[2] = '{32'h00000000, 24'h7FFFFF, 1'b1, 1'b0, 32'h02000004, 32'h00000004, 1'b0, 1'b0};
      tbl[3] = '{32'h00000100, 24'h000000, 1'b1, 1'b1, 32'h00000108, 32'h00000104, 1'b1, 1'b1};
      tbl[4] = '{32'h00002000, 24'hFFFFFF, 1'b0, 1'b0, 32'h00002004, 32'h00002004, 1'b0, 1'b0};
      tbl[5] = '{32'h80000000, 24'h800000, 1'b1, 1'b1, 32'h7E000008, 32'h80000004, 1'b1, 1'b1};
      idle   = '{32'h0, 24'h0, 1'b0, 1'b0, 32'h8, 32'h4, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      pc = '0; ofst = '0; link = 1'b0; cond_pass = 1'b0; stimVec = idle;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("rst_target", target, 32'd0);
      checkOutput("rst_link_addr", link_addr, 32'd0);
      checkOutput("rst_taken", {31'd0, taken}, 32'd0);
      checkOutput("rst_link_we", {31'd0, link_we}, 32'd0);
      checkOutput("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
      checkEn = 1'b1;

      for (int i = 0; i < 6; i++)
         applyStimulus(tbl[i], 1'b1, 1'b1, 1'b0);
      repeat (2) applyStimulus(idle, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("table_taken_cnt", {16'd0, taken_cnt}, 32'd4);

      // Backpressure: hold a result for 3 cycles, then release with a new request
      applyStimulus(tbl[1], 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(tbl[3], 1'b1, 1'b0, 1'b0);
         @(negedge clk);
         checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("bp_target", target, 32'h00000004);
      end
      applyStimulus(tbl[5], 1'b1, 1'b1, 1'b0);
      applyStimulus(idle, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("bp_next_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_next_target", target, 32'h7E000008);
      applyStimulus(idle, 1'b0, 1'b1, 1'b0);

      // Flush while holding a taken result with a same-cycle request
      applyStimulus(tbl[0], 1'b1, 1'b0, 1'b0);
      applyStimulus(tbl[3], 1'b1, 1'b1, 1'b1);
      applyStimulus(idle, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_taken_cnt", {16'd0, taken_cnt}, 32'd6);

      // Reset in the middle of a held result
      applyStimulus(tbl[1], 1'b1, 1'b0, 1'b0);
      applyStimulus(tbl[3], 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("mid_rst_target", target, 32'd0);
      checkOutput("mid_rst_link_addr", link_addr, 32'd0);
      checkOutput("mid_rst_taken", {31'd0, taken}, 32'd0);
      checkOutput("mid_rst_link_we", {31'd0, link_we}, 32'd0);
      checkOutput("mid_rst_cnt", {16'd0, taken_cnt}, 32'd0);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(refVec($urandom, 24'($urandom), 1'($urandom), 1'($urandom)),
                       ($urandom_range(0, 9) < 7), 1'($urandom),
                       ($urandom_range(0, 9) == 0));
      end
      repeat (2) applyStimulus(idle, 1'b0, 1'b1, 1'b0);

      // Counter wrap: stream taken branches until the count reaches 16'hFFFF
      checkEn = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      pre = refVec(32'h00000040, 24'h000001, 1'b0, 1'b1);
      applyStimulus(pre, 1'b1, 1'b1, 1'b0);
      guard = 0;
      while (expCnt != 16'hFFFF && guard < 70000) begin
         @(negedge clk);
         guard++;
      end
      if (expCnt != 16'hFFFF)
         checkOutput("wrap_timeout", {16'd0, expCnt}, 32'h0000FFFF);
      checkOutput("wrap_pre", {16'd0, taken_cnt}, 32'h0000FFFF);
      @(negedge clk);
      checkOutput("wrap_zero", {16'd0, taken_cnt}, 32'h00000000);
      checkEn = 1'b1;
      repeat (2) applyStimulus(idle, 1'b0, 1'b1, 1'b0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
